// File: rtl/note_selector_pkg.sv
// audio_pkg: shared audio constants, note increment table and note selector FSM encoding
package audio_pkg;

    localparam int BITDEPTH    = 14;
    localparam int BITFRACTION = 6;
    localparam int SAMPLEFREQ  = 31250;
    localparam int INCBITS     = 21;
    localparam int NUM_KEYS    = 8;

    // Phase increments for C4..C5: truncate(hz * 2^20 / 31250 * 2)
    localparam logic [INCBITS-1:0] NOTE_INC [NUM_KEYS] = '{
        21'd17582, 21'd19730, 21'd22145, 21'd23420,
        21'd26306, 21'd29527, 21'd33151, 21'd35097
    };

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        PLAY   = 2'd1,
        RETRIG = 2'd2
    } state_e;

    // Index of the lowest set bit; 0 when nothing is set
    function automatic logic [2:0] lowest_idx(input logic [NUM_KEYS-1:0] v);
        lowest_idx = '0;
        for (int i = NUM_KEYS - 1; i >= 0; i--)
            if (v[i]) lowest_idx = 3'(i);
    endfunction

endpackage

// File: rtl/note_selector_if.sv
// note_selector_if: button inputs and pitch/gate/LED outputs of the note selector
interface note_selector_if
    import audio_pkg::*;
#(
    parameter int NUM_KEYS = 8
);
    logic [NUM_KEYS-1:0] btn;
    logic [INCBITS-1:0]  increment;
    logic                gate;
    logic [2:0]          key_index;
    logic [NUM_KEYS-1:0] held;

    modport master (output btn, input increment, gate, key_index, held);
    modport slave  (input btn, output increment, gate, key_index, held);
endinterface

// File: rtl/note_selector_key_debounce.sv
// key_debounce: synchronises and debounces one active-low button, flags press/release edges
module key_debounce #(
    parameter int unsigned DEBOUNCE_CYCLES = 40000
) (
    input  logic clk,
    input  logic reset_n,
    input  logic btn_i,
    output logic held_o,
    output logic press_o,
    output logic release_o
);
    localparam int unsigned CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam int unsigned LAST = (DEBOUNCE_CYCLES > 0) ? DEBOUNCE_CYCLES - 1 : 0;
    localparam logic [CW-1:0] CNT_LAST = CW'(LAST);

    logic          meta_q, sync_q, stable_q, stable_d;
    logic          press_q, press_d, release_q, release_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          accept;

    // Accept the synchronised level once it has disagreed with the stable level long enough
    always_comb begin
        accept    = (sync_q != stable_q) && (cnt_q == CNT_LAST);
        stable_d  = accept ? sync_q : stable_q;
        cnt_d     = ((sync_q == stable_q) || accept) ? '0 : cnt_q + 1'b1;
        press_d   = accept & ~sync_q;
        release_d = accept & sync_q;
    end

    // Two-flop synchroniser, debounce counter and edge pulses aligned with the held change
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            meta_q    <= 1'b1;
            sync_q    <= 1'b1;
            stable_q  <= 1'b1;
            cnt_q     <= '0;
            press_q   <= 1'b0;
            release_q <= 1'b0;
        end else begin
            meta_q    <= btn_i;
            sync_q    <= meta_q;
            stable_q  <= stable_d;
            cnt_q     <= cnt_d;
            press_q   <= press_d;
            release_q <= release_d;
        end
    end

    assign held_o    = ~stable_q;
    assign press_o   = press_q;
    assign release_o = release_q;
endmodule

// File: rtl/note_selector.sv
// note_selector: last-pressed note priority with gate retrigger for the mono synth voice
module note_selector
    import audio_pkg::*;
#(
    parameter int unsigned NUM_KEYS         = 8,
    parameter int unsigned DEBOUNCE_CYCLES  = 40000,
    parameter int unsigned RETRIGGER_CYCLES = 256
) (
    input logic             clk,
    input logic             reset_n,
    note_selector_if.slave  bus
);
    localparam int unsigned RW = (RETRIGGER_CYCLES > 1) ? $clog2(RETRIGGER_CYCLES) : 1;
    localparam int unsigned RL = (RETRIGGER_CYCLES > 0) ? RETRIGGER_CYCLES - 1 : 0;
    localparam logic [RW-1:0] RLAST = RW'(RL);

    logic [NUM_KEYS-1:0] held, press, rel;
    state_e              state_q, state_d;
    logic [2:0]          key_q, key_d;
    logic [RW-1:0]       rcnt_q, rcnt_d;
    logic [INCBITS-1:0]  inc_q, inc_d;
    logic                gate_q, gate_d;
    logic                any_press, cur_rel, none_held;
    logic [2:0]          new_key, legato_key;

    for (genvar k = 0; k < NUM_KEYS; k++) begin : g_key
        key_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb (
            .clk       (clk),
            .reset_n   (reset_n),
            .btn_i     (bus.btn[k]),
            .held_o    (held[k]),
            .press_o   (press[k]),
            .release_o (rel[k])
        );
    end

    // Next key, retrigger counter and state from this cycle's press/release events
    always_comb begin
        state_d    = state_q;
        key_d      = key_q;
        rcnt_d     = rcnt_q;
        any_press  = |press;
        none_held  = (held == '0);
        new_key    = lowest_idx(press);
        legato_key = lowest_idx(held);
        cur_rel    = rel[key_q] && !any_press;
        case (state_q)
            IDLE: begin
                if (any_press) begin
                    state_d = PLAY;
                    key_d   = new_key;
                end
            end
            PLAY: begin
                if (none_held) begin
                    state_d = IDLE;
                end else if (any_press) begin
                    key_d = new_key;
                    if (RETRIGGER_CYCLES > 0) begin
                        state_d = RETRIG;
                        rcnt_d  = '0;
                    end
                end else if (cur_rel) begin
                    key_d = legato_key;
                end
            end
            RETRIG: begin
                if (none_held) begin
                    state_d = IDLE;
                end else if (any_press) begin
                    key_d  = new_key;
                    rcnt_d = '0;
                end else begin
                    if (cur_rel) key_d = legato_key;
                    if (rcnt_q == RLAST) state_d = PLAY;
                    else rcnt_d = rcnt_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
        inc_d  = NOTE_INC[key_d];
        gate_d = (state_d == PLAY);
    end

    // FSM state and registered outputs
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            key_q   <= '0;
            rcnt_q  <= '0;
            inc_q   <= NOTE_INC[0];
            gate_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            key_q   <= key_d;
            rcnt_q  <= rcnt_d;
            inc_q   <= inc_d;
            gate_q  <= gate_d;
        end
    end

    assign bus.increment = inc_q;
    assign bus.gate      = gate_q;
    assign bus.key_index = key_q;
    assign bus.held      = held;
endmodule
